// File: rtl/mem_stage_pkg.sv
// Shared encodings and store-lane helpers for the memory stage.
package mem_stage_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [2:0] SX_LB  = 3'b001;
  localparam logic [2:0] SX_LBU = 3'b010;
  localparam logic [2:0] SX_LH  = 3'b011;
  localparam logic [2:0] SX_LHU = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Byte offset actually used for an access: halves drop a[0], words drop a[1:0].
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_B:  return a;
      SIZE_H:  return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobes(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SIZE_B:  return {4{d[7:0]}};
      SIZE_H:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shift the addressed lane down, then sign/zero-extend.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  sx_ctrl_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    case (sx_ctrl_i)
      SX_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      SX_LBU:  data_o = {24'h0, shifted[7:0]};
      SX_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      SX_LHU:  data_o = {16'h0, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: req/ack data-memory access with upstream stall and registered writeback.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] st_data_i,
  input  logic [4:0]  rd_i,
  input  logic [1:0]  cmd_i,
  input  logic [1:0]  be_mem_i,
  input  logic [2:0]  sx_ctrl_i,
  input  logic        we_reg_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_we_o,
  output logic        err_o,
  output logic        misalign_o
);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  sx_q, sx_d;
  logic [1:0]  off_q, off_d;
  logic        ld_we_q, ld_we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic        err_q, err_d, mis_q, mis_d;

  logic        is_mem, misalign, issue, ack_hit, timeout;
  logic [1:0]  off;
  logic [31:0] ld_data;

  assign is_mem = (cmd_i == CMD_LOAD) || (cmd_i == CMD_STORE);
  assign off    = align_offset(be_mem_i, alu_res_i[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  // Any bits the alignment would discard mean the access is misaligned.
  assign misalign = is_mem && (off != alu_res_i[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign issue   = (state_q == ST_IDLE) && is_mem && !flush_i && !misalign;
  assign ack_hit = (state_q == ST_REQ) && dmem_ack_i;
  assign timeout = (state_q == ST_REQ) && !dmem_ack_i && (cnt_q == 8'(TIMEOUT_CYC - 1));
  assign stall_o = issue || ((state_q == ST_REQ) && !dmem_ack_i && !timeout);

  mem_stage_load_align u_load_align (
    .rdata_i   (dmem_rdata_i),
    .off_i     (off_q),
    .sx_ctrl_i (sx_q),
    .data_o    (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_d      = rd_q;
    sx_d      = sx_q;
    off_d     = off_q;
    ld_we_d   = ld_we_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = 1'b0;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = 8'h00;
        wb_data_d = alu_res_i;
        wb_rd_d   = rd_i;
        wb_we_d   = !is_mem && we_reg_i && !flush_i;
        mis_d     = is_mem && !flush_i && misalign;
        if (issue) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = (cmd_i == CMD_STORE);
          addr_d  = {alu_res_i[31:2], 2'b00};
          be_d    = byte_strobes(be_mem_i, off);
          wdata_d = lane_data(be_mem_i, st_data_i);
          rd_d    = rd_i;
          sx_d    = sx_ctrl_i;
          off_d   = off;
          ld_we_d = we_reg_i;
        end
      end
      default: begin
        cnt_d = cnt_q + 8'd1;
        if (ack_hit) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_data_d = ld_data;
            wb_rd_d   = rd_q;
            wb_we_d   = ld_we_q;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      rd_q      <= 5'h0;
      sx_q      <= 3'h0;
      off_q     <= 2'h0;
      ld_we_q   <= 1'b0;
      cnt_q     <= 8'h00;
      wb_data_q <= 32'h0;
      wb_rd_q   <= 5'h0;
      wb_we_q   <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rd_q      <= rd_d;
      sx_q      <= sx_d;
      off_q     <= off_d;
      ld_we_q   <= ld_we_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_data_o    = wb_data_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_we_o      = wb_we_q;
  assign err_o        = err_q;
  assign misalign_o   = mis_q;

endmodule
